pipe_loop_fifo: RTL
===================

# pipe_loop_fifo

Block-granular loopback FIFO between the host BTPipeIn and BTPipeOut endpoints on `ti_clk`. Accepts 16-bit words from the pipe-in stage, buffers them, and presents them in order to the pipe-out stage. Ready/valid flags are asserted only when a whole transfer block fits or is available, matching block-throttled pipe semantics. Exposes occupancy, block and error counters for WireOuts.

## Interface
- `DEPTH_LOG2`, 10: log2 of FIFO depth in 16-bit words (1024).
- `BLOCK_WORDS`, 256: words per host block. Power of two, ≤ 2^DEPTH_LOG2 / 2.
- `clk` in 1: `ti_clk`; every register is clocked on the rising edge.
- `reset` in 1: synchronous, active-high.
- `pipe_in_write` in 1: one write strobe per accepted host word.
- `pipe_in_data` in 16: write word, qualified by `pipe_in_write`.
- `pipe_in_ready` out 1: free space ≥ BLOCK_WORDS.
- `pipe_out_read` in 1: consume the head word.
- `pipe_out_data` out 16: head word (first-word-fall-through).
- `pipe_out_valid` out 1: occupancy ≥ BLOCK_WORDS.
- `count` out DEPTH_LOG2+1: current occupancy, 0..2^DEPTH_LOG2.
- `blocks_in` out 16: completed input blocks, wraps modulo 2^16.
- `blocks_out` out 16: completed output blocks, wraps modulo 2^16.
- `overflow_count` out 16: dropped writes, saturates at 16'hFFFF.
- `underflow_count` out 16: reads while empty, saturates at 16'hFFFF.

## Operation
- Storage: 2^DEPTH_LOG2 × 16 memory. Write and read pointers are DEPTH_LOG2 bits and wrap naturally. `count` is tracked separately so full and empty are unambiguous.
- Write accepted iff `pipe_in_write` && pre-edge `count` < 2^DEPTH_LOG2. On accept: store word, advance write pointer.
- Write with `count` = full: word dropped, pointers unchanged, `overflow_count` += 1. This applies even if a read occurs in the same cycle, because the full test uses the pre-edge count.
- Read accepted iff `pipe_out_read` && pre-edge `count` > 0. On accept: advance read pointer.
- Read with `count` = 0: `underflow_count` += 1, pointers unchanged. A write in the same cycle is still accepted; there is no same-cycle fall-through.
- Count update: accepted write and accepted read together → unchanged; write only → +1; read only → −1.
- Block counters:
  - Internal in/out word counters of log2(BLOCK_WORDS) bits count accepted words only.
  - When a counter wraps to 0, the matching `blocks_in` or `blocks_out` increments.
- `pipe_in_ready` is registered from the next-state count: 1 iff (2^DEPTH_LOG2 − next_count) ≥ BLOCK_WORDS.
- `pipe_out_valid` is registered from the next-state count: 1 iff next_count ≥ BLOCK_WORDS.
- Flags are evaluated per word. The host guarantees it only starts a block when the flag is set, so a whole block is always covered.
- `pipe_out_data`:
  - Shows mem[read pointer] whenever `count` > 0.
  - Shows 16'h0000 whenever `count` = 0.
  - Implemented with a prefetch register or asynchronous-read memory; externally it is FWFT.
- Reset (synchronous): pointers, `count`, word/block counters and error counters go to 0. `pipe_in_ready` = 0, `pipe_out_valid` = 0, `pipe_out_data` = 16'h0000. Memory contents are not cleared. Reset asserted mid-transfer discards all buffered data and overrides any same-cycle write or read.

## Timing
- `count`, `pipe_in_ready` and `pipe_out_valid` change on the same edge as the write/read that causes them; there is no extra lag cycle.
- Write-to-head latency from empty: a word written at edge N appears on `pipe_out_data` after edge N, and is readable at edge N+1.
- Read-to-next-head: after a read at edge N, the next word is valid on `pipe_out_data` after edge N.
- First cycle after reset deasserts: `pipe_in_ready` = 1 (free = depth) and `pipe_out_valid` = 0. Both are evaluated on the first non-reset edge.
- Sustained throughput: one write and one read per cycle, simultaneously, with no bubbles.

## Test plan
- Reset check:
  - During reset: all outputs 0.
  - First edge after release: `pipe_in_ready` = 1, `pipe_out_valid` = 0, `count` = 0.
- Single block:
  - Write 0x0000..0x00FF (256 words) → `pipe_out_valid` = 1 at the edge of the 256th write, `count` = 256, `blocks_in` = 1.
  - Read 256 → data 0x0000..0x00FF in order, `count` = 0, `pipe_out_valid` = 0, `blocks_out` = 1.
- Fill and overflow:
  - Write 768 words → `pipe_in_ready` still 1.
  - 769th write → `pipe_in_ready` = 0.
  - Fill to 1024 → `count` = 1024.
  - 1025th write (0xBEEF) → dropped, `overflow_count` = 1.
  - Drain → 0xBEEF is never returned.
- Underflow: read at `count` = 0 → `underflow_count` = 1, `pipe_out_data` = 0x0000. Same cycle with a write → `count` = 1, and the written word is on `pipe_out_data` next cycle.
- Wrap and concurrency:
  - Prefill 300 words, then stream 3000 incrementing words with simultaneous read every cycle → `count` stays 300 and the output sequence is contiguous across pointer wrap.
  - 3300 written / 3300 read completes with `blocks_in` = 12, `blocks_out` = 12.
- Reset mid-operation: at `count` = 500, assert reset for 1 cycle together with a write → `count` = 0, the write is ignored, all counters are 0, and `pipe_in_ready` = 1 on the next edge.

Source files
------------

// File: rtl/pipe_loop_fifo.sv
// Block-granular loopback FIFO between host pipe-in and pipe-out endpoints.
// Ready/valid flags only advertise whole blocks of space or data.
module pipe_loop_fifo #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned BLOCK_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pipe_in_write,
    input  logic [15:0]           pipe_in_data,
    output logic                  pipe_in_ready,
    input  logic                  pipe_out_read,
    output logic [15:0]           pipe_out_data,
    output logic                  pipe_out_valid,
    output logic [DEPTH_LOG2:0]   count,
    output logic [15:0]           blocks_in,
    output logic [15:0]           blocks_out,
    output logic [15:0]           overflow_count,
    output logic [15:0]           underflow_count
);

    localparam int unsigned Depth  = 1 << DEPTH_LOG2;
    localparam int unsigned CW     = DEPTH_LOG2 + 1;
    localparam int unsigned BwBits = $clog2(BLOCK_WORDS);

    localparam logic [CW-1:0]         DepthCnt = CW'(Depth);
    localparam logic [CW-1:0]         BlockCnt = CW'(BLOCK_WORDS);
    localparam logic [CW-1:0]         CntOne   = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PtrOne   = DEPTH_LOG2'(1);
    localparam logic [BwBits-1:0]     WordOne  = BwBits'(1);

    logic [15:0] mem [Depth];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d, free_d;
    logic [BwBits-1:0]     in_word_q, out_word_q;
    logic [15:0]           blocks_in_q, blocks_out_q, ovf_q, unf_q;
    logic                  ready_q, ready_d, valid_q, valid_d;
    logic                  full, empty, wr_acc, rd_acc;

    always_comb begin
        full    = (count_q == DepthCnt);
        empty   = (count_q == '0);
        // Full/empty tests use the pre-edge count, so no same-cycle pass-through.
        wr_acc  = pipe_in_write && !full;
        rd_acc  = pipe_out_read && !empty;
        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CntOne;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CntOne;
        end
        free_d  = DepthCnt - count_d;
        ready_d = (free_d >= BlockCnt);
        valid_d = (count_d >= BlockCnt);
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !reset) begin
            mem[wr_ptr_q] <= pipe_in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            in_word_q    <= '0;
            out_word_q   <= '0;
            blocks_in_q  <= '0;
            blocks_out_q <= '0;
            ovf_q        <= '0;
            unf_q        <= '0;
            ready_q      <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            count_q <= count_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            if (wr_acc) begin
                wr_ptr_q  <= wr_ptr_q + PtrOne;
                in_word_q <= in_word_q + WordOne;
                if (in_word_q == '1) begin
                    blocks_in_q <= blocks_in_q + 16'd1;
                end
            end
            if (rd_acc) begin
                rd_ptr_q   <= rd_ptr_q + PtrOne;
                out_word_q <= out_word_q + WordOne;
                if (out_word_q == '1) begin
                    blocks_out_q <= blocks_out_q + 16'd1;
                end
            end
            if (pipe_in_write && full && ovf_q != 16'hFFFF) begin
                ovf_q <= ovf_q + 16'd1;
            end
            if (pipe_out_read && empty && unf_q != 16'hFFFF) begin
                unf_q <= unf_q + 16'd1;
            end
        end
    end

    always_comb begin
        pipe_out_data   = empty ? 16'h0000 : mem[rd_ptr_q];
        pipe_in_ready   = ready_q;
        pipe_out_valid  = valid_q;
        count           = count_q;
        blocks_in       = blocks_in_q;
        blocks_out      = blocks_out_q;
        overflow_count  = ovf_q;
        underflow_count = unf_q;
    end

endmodule
